mult_controlunit: RTL and testbench

Parametrised control unit for the sequential shift-add multiplier datapath. It is the successor to the two-state load/multiply controller.
- Accepts operands through a valid/ack handshake.
- Sequences WIDTH add/shift iterations, with optional early exit when the remaining multiplier is zero.
- Holds the result under a valid/ready output handshake.
- Sits between the operand source and the multiplier datapath registers.

---
 rtl/mult_controlunit_if.sv | 49 ++++
 rtl/mult_controlunit.sv | 104 ++++++++++
 tb/tb_mult_controlunit.sv | 257 +++++++++++++++++++++++++
 3 files changed

// File: rtl/mult_controlunit_if.sv
// Handshake and datapath-control bundle between the shift-add multiplier controller
// and its operand source / datapath.
interface mult_controlunit_if #(
    parameter int unsigned WIDTH = 8
);
    localparam int unsigned CW = $clog2(WIDTH + 1);

    logic          inputdata_ready;
    logic          inputdata_ack;
    logic          loaddata;
    logic          multiplier_lsb;
    logic          multiplier_zero;
    logic          addenable;
    logic          shiftenable;
    logic          result_valid;
    logic          result_ready;
    logic          busy;
    logic [CW-1:0] count;

    // Environment side: operand source, datapath status and result consumer
    modport master (
        output inputdata_ready,
        output multiplier_lsb,
        output multiplier_zero,
        output result_ready,
        input  inputdata_ack,
        input  loaddata,
        input  addenable,
        input  shiftenable,
        input  result_valid,
        input  busy,
        input  count
    );

    // Controller side
    modport slave (
        input  inputdata_ready,
        input  multiplier_lsb,
        input  multiplier_zero,
        input  result_ready,
        output inputdata_ack,
        output loaddata,
        output addenable,
        output shiftenable,
        output result_valid,
        output busy,
        output count
    );
endinterface

// File: rtl/mult_controlunit.sv
// Sequencing controller for a shift-add multiplier datapath: operand handshake,
// WIDTH add/shift iterations with optional early exit, held result handshake.
module mult_controlunit #(
    parameter int unsigned WIDTH      = 8,
    parameter bit          EARLY_EXIT = 1'b0,
    parameter int unsigned CW         = $clog2(WIDTH + 1)
) (
    input  logic                clk,
    input  logic                reset,
    mult_controlunit_if.slave   bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        CALC = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);

    state_t        state;
    logic [CW-1:0] count_q;
    logic          ack_q;
    logic          load_q;
    logic          busy_q;
    logic          valid_q;

    logic          exit_c;
    logic          step_c;

    // Mealy step decode: a CALC cycle either performs one add/shift step or observes zero
    always_comb begin
        exit_c = EARLY_EXIT && bus.multiplier_zero;
        step_c = (state == CALC) && !exit_c;
    end

    // State and registered outputs; ack only rises after the first edge out of reset
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            count_q <= '0;
            ack_q   <= 1'b0;
            load_q  <= 1'b0;
            busy_q  <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (ack_q && bus.inputdata_ready) begin
                        state   <= LOAD;
                        ack_q   <= 1'b0;
                        load_q  <= 1'b1;
                        busy_q  <= 1'b1;
                        count_q <= '0;
                    end else begin
                        ack_q <= 1'b1;
                    end
                end
                LOAD: begin
                    state  <= CALC;
                    load_q <= 1'b0;
                end
                CALC: begin
                    if (exit_c) begin
                        state   <= DONE;
                        busy_q  <= 1'b0;
                        valid_q <= 1'b1;
                    end else begin
                        count_q <= count_q + CW'(1);
                        if (count_q == LAST_STEP) begin
                            state   <= DONE;
                            busy_q  <= 1'b0;
                            valid_q <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    if (bus.result_ready) begin
                        state   <= IDLE;
                        valid_q <= 1'b0;
                        ack_q   <= 1'b1;
                    end
                end
                default: begin
                    state   <= IDLE;
                    ack_q   <= 1'b0;
                    load_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.inputdata_ack = ack_q;
    assign bus.loaddata      = load_q;
    assign bus.busy          = busy_q;
    assign bus.result_valid  = valid_q;
    assign bus.count         = count_q;
    assign bus.shiftenable   = step_c;
    assign bus.addenable     = step_c && bus.multiplier_lsb;

endmodule

// File: tb/tb_mult_controlunit.sv
// Self-checking bench: three controller configurations (8/no-exit, 8/early-exit, 16/no-exit),
// each driving a shift-add datapath model, checked against an arithmetic reference.
module tb_mult_controlunit;

    localparam int NDUT = 3;

    logic clk;
    logic reset;

    logic [NDUT-1:0]       in_ready;
    logic [NDUT-1:0]       res_ready;
    logic [NDUT-1:0]       ack_v, load_v, busy_v, valid_v, add_v, shift_v;
    logic [NDUT-1:0][7:0]  cnt_v;
    logic [NDUT-1:0][63:0] acc_v;
    logic [63:0]           mcand_in  [NDUT];
    logic [63:0]           mplier_in [NDUT];

    int vectors     = 0;
    int miscompares = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    for (genvar g = 0; g < NDUT; g++) begin : g_dut
        localparam int unsigned W  = (g == 2) ? 16 : 8;
        localparam bit          EE = (g == 1);
        localparam logic [63:0] M  = (64'd1 << W) - 64'd1;

        logic [63:0] mc, mp, acc;

        mult_controlunit_if #(.WIDTH(W)) bus ();

        mult_controlunit #(.WIDTH(W), .EARLY_EXIT(EE)) dut (
            .clk   (clk),
            .reset (reset),
            .bus   (bus)
        );

        assign bus.inputdata_ready = in_ready[g];
        assign bus.result_ready    = res_ready[g];
        assign bus.multiplier_lsb  = mp[0];
        assign bus.multiplier_zero = (mp == 64'd0);

        assign ack_v[g]   = bus.inputdata_ack;
        assign load_v[g]  = bus.loaddata;
        assign busy_v[g]  = bus.busy;
        assign valid_v[g] = bus.result_valid;
        assign add_v[g]   = bus.addenable;
        assign shift_v[g] = bus.shiftenable;
        assign cnt_v[g]   = 8'(bus.count);
        assign acc_v[g]   = acc;

        // Datapath registers steered by the controller
        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                mc  <= 64'd0;
                mp  <= 64'd0;
                acc <= 64'd0;
            end else if (bus.loaddata) begin
                mc  <= mcand_in[g] & M;
                mp  <= mplier_in[g] & M;
                acc <= 64'd0;
            end else begin
                if (bus.addenable) acc <= acc + mc;
                if (bus.shiftenable) begin
                    mc <= mc << 1;
                    mp <= mp >> 1;
                end
            end
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int w_of(input int d);
        return (d == 2) ? 16 : 8;
    endfunction

    function automatic bit ee_of(input int d);
        return d == 1;
    endfunction

    function automatic logic [63:0] mask_of(input int d);
        return (64'd1 << w_of(d)) - 64'd1;
    endfunction

    // Number of add/shift steps: all WIDTH bits, or up to the top set bit with early exit
    function automatic int steps_of(input int d, input logic [63:0] m);
        int s;
        if (!ee_of(d)) return w_of(d);
        s = 0;
        for (int i = 0; i < w_of(d); i++) if (m[i]) s = i + 1;
        return s;
    endfunction

    // One full operation on DUT d; must be called right after a falling edge
    task automatic run_op(input int d, input logic [63:0] mc, input logic [63:0] mp,
                          input int hold, input bit keep_req);
        logic [63:0] mcm, mpm, addpat, exp_pat;
        int steps, calc, lat, loads, shifts, stray, first, n;
        mcm     = mc & mask_of(d);
        mpm     = mp & mask_of(d);
        steps   = steps_of(d, mpm);
        calc    = ee_of(d) ? ((steps == w_of(d)) ? w_of(d) : steps + 1) : w_of(d);
        lat     = calc + 2;
        exp_pat = mpm & ((64'd1 << steps) - 64'd1);
        addpat  = 64'd0;
        loads = 0; shifts = 0; stray = 0; first = 0;

        mcand_in[d]  = mc;
        mplier_in[d] = mp;
        res_ready[d] = (hold == 0);
        in_ready[d]  = 1'b1;
        n = 0;
        while (!ack_v[d] && n < 300) begin
            @(negedge clk);
            n++;
        end
        check("accept_wait", 64'(ack_v[d]), 64'd1);
        if (!ack_v[d]) begin
            in_ready[d] = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        if (!keep_req) in_ready[d] = 1'b0;

        for (int cyc = 1; cyc <= 100; cyc++) begin
            @(negedge clk);
            if (load_v[d]) loads++;
            if ((add_v[d] || shift_v[d]) && (!busy_v[d] || load_v[d] || valid_v[d])) stray++;
            if (add_v[d] && !shift_v[d]) stray++;
            if (shift_v[d]) begin
                addpat[shifts] = add_v[d];
                shifts++;
            end
            if (valid_v[d]) begin
                first = cyc;
                break;
            end
        end
        check("valid_latency", 64'(first), 64'(lat));
        check("load_pulses", 64'(loads), 64'd1);
        check("shift_cycles", 64'(shifts), 64'(steps));
        check("add_pattern", addpat, exp_pat);
        check("final_count", 64'(cnt_v[d]), 64'(steps));
        check("product", acc_v[d], mcm * mpm);
        check("stray_enables", 64'(stray), 64'd0);

        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check("bp_valid", 64'(valid_v[d]), 64'd1);
            check("bp_ack", 64'(ack_v[d]), 64'd0);
        end
        res_ready[d] = 1'b1;
        @(negedge clk);
        check("post_valid", 64'(valid_v[d]), 64'd0);
        check("post_ack", 64'(ack_v[d]), 64'd1);

        if (keep_req) begin
            @(negedge clk);
            check("next_load", 64'(load_v[d]), 64'd1);
            in_ready[d] = 1'b0;
            n = 0;
            while (!ack_v[d] && n < 100) begin
                @(negedge clk);
                n++;
            end
            check("drain", 64'(ack_v[d]), 64'd1);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic [63:0] ra, rb;
        int d, hold, n, seen;
        reset     = 1'b0;
        in_ready  = '0;
        res_ready = '1;
        for (int i = 0; i < NDUT; i++) begin
            mcand_in[i]  = 64'd0;
            mplier_in[i] = 64'd0;
        end

        // Reset held for three cycles: everything low
        repeat (3) begin
            @(negedge clk);
            check("rst_outputs", 64'({ack_v, load_v, busy_v, valid_v, add_v, shift_v}), 64'd0);
            check("rst_count", 64'(cnt_v), 64'd0);
        end
        reset = 1'b1;
        @(negedge clk);
        check("ack_after_rst", 64'(ack_v), 64'b111);
        check("count_after_rst", 64'(cnt_v), 64'd0);

        // Directed cases
        run_op(0, 64'h3C, 64'hA5, 0, 1'b0);
        run_op(1, 64'h3C, 64'h03, 0, 1'b0);
        run_op(1, 64'h77, 64'h00, 0, 1'b0);
        run_op(0, 64'h19, 64'h6E, 5, 1'b1);
        run_op(1, 64'hD2, 64'h81, 3, 1'b1);

        // Reset in the middle of CALC
        mcand_in[0]  = 64'h5A;
        mplier_in[0] = 64'hFF;
        in_ready[0]  = 1'b1;
        @(posedge clk);
        #1;
        in_ready[0] = 1'b0;
        n = 0;
        while (cnt_v[0] != 8'd4 && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("midcalc_busy", 64'(busy_v[0]), 64'd1);
        #2 reset = 1'b0;
        #1;
        check("async_clear", 64'({ack_v, load_v, busy_v, valid_v, add_v, shift_v}), 64'd0);
        check("async_count", 64'(cnt_v), 64'd0);
        @(negedge clk);
        reset = 1'b1;
        seen = 0;
        repeat (4) begin
            @(negedge clk);
            if (valid_v[0]) seen++;
        end
        check("no_valid_after_rst", 64'(seen), 64'd0);
        check("ack_after_midrst", 64'(ack_v), 64'b111);

        run_op(2, 64'h1234, 64'hBEEF, 0, 1'b0);

        // Randomized operations across all configurations
        for (int t = 0; t < 36; t++) begin
            d    = $urandom_range(0, NDUT - 1);
            ra   = {32'd0, $urandom};
            rb   = {32'd0, $urandom} & ((64'd1 << $urandom_range(0, w_of(d))) - 64'd1);
            hold = $urandom_range(0, 3);
            run_op(d, ra, rb, hold, 1'b0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
